// File: rtl/wb_pwm_fader_pkg.sv
// Shared definitions for the Wishbone PWM fader: FSM state encodings and the
// ack-timeout length used when WB_PWM_FADER_TIMEOUT_EN is defined.
package wb_pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_SCAN     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WAIT_ACK = 3'd4
    } fader_state_t;

    // Cycles spent in WAIT_ACK without an ack before the transfer is abandoned.
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);

endpackage

// File: rtl/wb_pwm_fader_if.sv
// Wishbone B4 pipelined write-only link between the fader (master) and the
// PWM peripheral slave port.
interface wb_pwm_fader_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic        wbm_stall_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_stall_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_stall_i
    );

endinterface

// File: rtl/wb_pwm_fader_chan.sv
// One fader channel: target and current duty plus a dirty flag that marks a
// value not yet pushed to the PWM peripheral. Current moves one LSB toward
// target per step pulse.
module wb_pwm_fader_chan #(
    parameter int BITS = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            step,
    input  logic            clear_dirty,
    output logic [BITS-1:0] current,
    output logic            dirty
);

    logic [BITS-1:0] target;

    // Target load, one-LSB step toward target, and dirty tracking.
    // Dirty comes out of reset set so the first sweep pushes zeros everywhere.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            target  <= '0;
            current <= '0;
            dirty   <= 1'b1;
        end else begin
            if (load) begin
                target <= load_value;
            end
            if (step) begin
                if (current < target) begin
                    current <= current + 1'b1;
                    dirty   <= 1'b1;
                end else if (current > target) begin
                    current <= current - 1'b1;
                    dirty   <= 1'b1;
                end
            end else if (clear_dirty) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_pwm_fader.sv
// Wishbone PWM fader: steps every channel's duty one LSB toward its target on
// each prescaler tick and writes each changed value to the PWM peripheral.
// Optional build macro: WB_PWM_FADER_TIMEOUT_EN adds a 16-cycle ack timeout
// with a sticky err flag; without it WAIT_ACK waits forever and err is 0.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a prescaler tick (or a pending one)
// ST_STEP     | every channel moves one LSB toward its target
// ST_SCAN     | pick lowest-index dirty channel, or finish the sweep
// ST_WRITE    | cyc/stb/we asserted, waiting for the slave to take stb
// ST_WAIT_ACK | strobe accepted, cyc held until the slave acks
module wb_pwm_fader
    import wb_pwm_pkg::*;
#(
    parameter int BITS      = 4,
    parameter int CHANNELS  = 3,
    parameter int PRESCALE  = 1024,
    parameter int ADR_SHIFT = 0
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        tgt_valid,
    output logic                        tgt_ready,
    input  logic [$clog2(CHANNELS)-1:0] tgt_chan,
    input  logic [BITS-1:0]             tgt_value,
    wb_pwm_fader_if.master              wbm,
    output logic                        busy,
    output logic                        err
);

    localparam int CH_W = $clog2(CHANNELS);
    localparam int PS_W = $clog2(PRESCALE);

    fader_state_t state_q, state_d;

    logic [PS_W-1:0]     ps_cnt;
    logic                tick;
    logic                pending;
    logic [CH_W-1:0]     sel_q;
    logic [CH_W-1:0]     pick;
    logic                any_elig;
    logic [CHANNELS-1:0] dirty_vec;
    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] skip;
    logic [CHANNELS-1:0] clr_vec;
    logic [CHANNELS-1:0] load_vec;
    logic [BITS-1:0]     cur [CHANNELS];
    logic                step_en;
    logic                latch_sel;
    logic                ack_done;
    logic                timeout;

    // Channel registers; an out-of-range tgt_chan matches no instance and is dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign load_vec[i] = tgt_valid && (tgt_chan == CH_W'(i));
        assign clr_vec[i]  = ack_done && (sel_q == CH_W'(i));

        wb_pwm_fader_chan #(.BITS(BITS)) u_chan (
            .wb_clk_i    (wb_clk_i),
            .wb_rst_i    (wb_rst_i),
            .load        (load_vec[i]),
            .load_value  (tgt_value),
            .step        (step_en),
            .clear_dirty (clr_vec[i]),
            .current     (cur[i]),
            .dirty       (dirty_vec[i])
        );
    end

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    // Free-running prescaler, wraps at PRESCALE-1 and ticks on the wrap cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // One-deep memory of a tick that arrived mid-sweep; IDLE consumes it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pending <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end
    end

    // Ready is held low only while reset is applied.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tgt_ready <= 1'b0;
        end else begin
            tgt_ready <= 1'b1;
        end
    end

    assign elig     = dirty_vec & ~skip;
    assign any_elig = |elig;

    // Lowest-index eligible dirty channel.
    always_comb begin
        pick = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick = CH_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_d   = state_q;
        step_en   = 1'b0;
        latch_sel = 1'b0;
        ack_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick || pending) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                step_en = 1'b1;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (any_elig) begin
                    latch_sel = 1'b1;
                    state_d   = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!wbm.wbm_stall_i) begin
                    if (wbm.wbm_ack_i) begin
                        ack_done = 1'b1;
                        state_d  = ST_SCAN;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (wbm.wbm_ack_i) begin
                    ack_done = 1'b1;
                    state_d  = ST_SCAN;
                end else if (timeout) begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Selected channel is frozen from SCAN until the next SCAN so adr/dat stay put.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_q <= '0;
        end else if (latch_sel) begin
            sel_q <= pick;
        end
    end

`ifdef WB_PWM_FADER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [CHANNELS-1:0]  skip_q;
    logic                 err_q;

    assign timeout = (state_q == ST_WAIT_ACK) && !wbm.wbm_ack_i
                     && (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign skip    = skip_q;
    assign err     = err_q;

    // Ack timeout: counter runs only in WAIT_ACK; a timed-out channel stays
    // dirty but is skipped until the sweep ends, then retried next tick.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
            skip_q <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state_q == ST_WAIT_ACK) ? to_cnt + 1'b1 : '0;
            if (timeout) begin
                err_q         <= 1'b1;
                skip_q[sel_q] <= 1'b1;
            end
            if (state_q == ST_SCAN && !any_elig) begin
                skip_q <= '0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign skip    = '0;
    assign err     = 1'b0;
`endif

    assign busy          = (state_q != ST_IDLE);
    assign wbm.wbm_cyc_o = (state_q == ST_WRITE) || (state_q == ST_WAIT_ACK);
    assign wbm.wbm_stb_o = (state_q == ST_WRITE);
    assign wbm.wbm_we_o  = (state_q == ST_WRITE);
    assign wbm.wbm_adr_o = 32'(sel_q) << ADR_SHIFT;
    assign wbm.wbm_dat_o = 32'(cur[sel_q]);

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Testbench for wb_pwm_fader with PRESCALE=4 and a slave that acks one cycle
// after accepting a strobe. Expected writes are queued by the stimulus and
// checked by an independent bus monitor.
module tb_wb_pwm_fader;

    localparam int BITS     = 4;
    localparam int CHANNELS = 3;
    localparam int PRESCALE = 4;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [1:0] tgt_chan = 2'd0;
    logic [3:0] tgt_value = 4'd0;
    logic       busy;
    logic       err;

    wb_pwm_fader_if bus();

    wb_pwm_fader #(
        .BITS      (BITS),
        .CHANNELS  (CHANNELS),
        .PRESCALE  (PRESCALE),
        .ADR_SHIFT (0)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_chan  (tgt_chan),
        .tgt_value (tgt_value),
        .wbm       (bus),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_count = 0;
    logic        noack_en = 1'b0;
    logic [31:0] noack_adr = 32'd0;
    logic        acc;
    int          n, base, cyc_hi, b0;
    logic        prev_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int adr, input int dat);
        wr_t w;
        w.adr = adr;
        w.dat = dat;
        exp_q.push_back(w);
    endtask

    task automatic load(input logic [1:0] ch, input logic [3:0] val);
        @(posedge clk); #1;
        tgt_chan  = ch;
        tgt_value = val;
        tgt_valid = 1'b1;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: %0d writes still outstanding after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (12) @(negedge clk);
    endtask

    // Slave: ack one cycle after an accepted strobe, unless told to ignore an address.
    initial begin
        bus.wbm_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            acc = bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_stall_i && !rst
                  && !(noack_en && bus.wbm_adr_o == noack_adr);
            @(posedge clk); #1;
            bus.wbm_ack_i = acc;
        end
    end

    // Monitor: every accepted strobe is compared against the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_stall_i) begin
            wr_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got adr %0h dat %0h, expected no write",
                         bus.wbm_adr_o, bus.wbm_dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wbm_adr_o !== mon_e.adr || bus.wbm_dat_o !== mon_e.dat || bus.wbm_we_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL write: got adr %0h dat %0h we %0b, expected adr %0h dat %0h we 1",
                             bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o, mon_e.adr, mon_e.dat);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wbm_stall_i = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cyc",   32'(bus.wbm_cyc_o), 0);
        check("rst_stb",   32'(bus.wbm_stb_o), 0);
        check("rst_we",    32'(bus.wbm_we_o), 0);
        check("rst_adr",   bus.wbm_adr_o, 0);
        check("rst_dat",   bus.wbm_dat_o, 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_err",   32'(err), 0);
        check("rst_ready", 32'(tgt_ready), 0);

        // First tick after reset pushes 0 to every channel.
        push(0, 0); push(1, 0); push(2, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(tgt_ready), 1);
        wait_drain("reset_sweep", 100);

        cyc_hi = 0;
        b0 = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.wbm_cyc_o) cyc_hi++;
            if (!busy) b0 = 1;
        end
        check("idle_no_cyc", 32'(cyc_hi), 0);
        check("idle_busy_low", 32'(b0), 1);

        // Channel index 3 does not exist: no write may follow.
        base = wr_count;
        load(2'd3, 4'd7);
        repeat (40) @(negedge clk);
        check("illegal_chan_writes", 32'(wr_count - base), 0);

        // Ch1 fades 0 -> 3.
        push(1, 1); push(1, 2); push(1, 3);
        load(2'd1, 4'd3);
        wait_drain("ch1_fade", 150);

        // Ch0 up to 5.
        push(0, 1); push(0, 2); push(0, 3); push(0, 4); push(0, 5);
        load(2'd0, 4'd5);
        wait_drain("ch0_up", 250);

        // Ch0 down toward 2, reversed back to 5 after reaching 3.
        push(0, 4); push(0, 3);
        load(2'd0, 4'd2);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ch0_down_reached", 32'(exp_q.size()), 0);
        push(0, 4); push(0, 5);
        load(2'd0, 4'd5);
        wait_drain("ch0_reverse", 150);

        // Stall held for three WRITE cycles.
        bus.wbm_stall_i = 1'b1;
        base = wr_count;
        push(2, 1);
        load(2'd2, 4'd1);
        n = 0;
        @(negedge clk);
        while (!bus.wbm_stb_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stall_stb_seen", 32'(bus.wbm_stb_o), 1);
        check("stall_adr", bus.wbm_adr_o, 2);
        check("stall_dat", bus.wbm_dat_o, 1);
        repeat (2) begin
            @(negedge clk);
            check("stall_stb_hold", 32'(bus.wbm_stb_o), 1);
            check("stall_adr_hold", bus.wbm_adr_o, 2);
            check("stall_dat_hold", bus.wbm_dat_o, 1);
        end
        @(posedge clk); #1;
        bus.wbm_stall_i = 1'b0;
        wait_drain("stall_write", 60);
        check("stall_one_write", 32'(wr_count - base), 1);

        // Reset asserted while waiting for an ack.
        noack_adr = 32'd2;
        noack_en  = 1'b1;
        push(2, 2);
        load(2'd2, 4'd3);
        n = 0;
        @(negedge clk);
        while (!(bus.wbm_cyc_o && !bus.wbm_stb_o) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_ack_reached", 32'(bus.wbm_cyc_o && !bus.wbm_stb_o), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_cyc", 32'(bus.wbm_cyc_o), 0);
        check("async_rst_stb", 32'(bus.wbm_stb_o), 0);
        check("async_rst_busy", 32'(busy), 0);
        noack_en = 1'b0;
        push(0, 0); push(1, 0); push(2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_drain("post_reset_sweep", 100);

`ifdef WB_PWM_FADER_TIMEOUT_EN
        // Ch1 never acks: timeout, ch2 still written, ch1 retried next tick.
        push(1, 1); push(2, 1); push(1, 1);
        noack_adr = 32'd1;
        noack_en  = 1'b1;
        prev_busy = busy;
        n = 0;
        @(negedge clk);
        while (!(busy && !prev_busy) && n < 40) begin
            prev_busy = busy;
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        tgt_chan = 2'd2; tgt_value = 4'd1; tgt_valid = 1'b1;
        @(posedge clk); #1;
        tgt_chan = 2'd1;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(bus.wbm_stb_o && bus.wbm_adr_o == 32'd1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        @(negedge clk);
        while (bus.wbm_cyc_o && !bus.wbm_stb_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("timeout_len", 32'(n), 16);
        check("timeout_err", 32'(err), 1);
        noack_en = 1'b0;
        wait_drain("timeout_sweep", 120);
        check("err_sticky", 32'(err), 1);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
